// File: rtl/regfile_rat_if.sv
// regfile_rat_if: operand-read, rename-issue, commit and flush bundle for
// regfile_rat. The master (decoder/issue + ROB side) drives addresses and
// commands; the slave (register file) returns operand state and busy_cnt.
interface regfile_rat_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int ROB_W = 4,
  parameter int NRP   = 2
);
  localparam int REG_W = $clog2(NREG);

  logic [NRP*REG_W-1:0] rd_addr;
  logic [NRP*XLEN-1:0]  rd_val;
  logic [NRP-1:0]       rd_busy;
  logic [NRP*ROB_W-1:0] rd_tag;

  logic                 rdy;
  logic                 issue;
  logic [REG_W-1:0]     issue_rd;
  logic [ROB_W-1:0]     issue_tag;

  logic                 commit;
  logic [REG_W-1:0]     commit_rd;
  logic [ROB_W-1:0]     commit_tag;
  logic [XLEN-1:0]      commit_val;

  logic                 flush;
  logic [REG_W:0]       busy_cnt;

  modport master (
    output rd_addr, rdy, issue, issue_rd, issue_tag,
           commit, commit_rd, commit_tag, commit_val, flush,
    input  rd_val, rd_busy, rd_tag, busy_cnt
  );

  modport slave (
    input  rd_addr, rdy, issue, issue_rd, issue_tag,
           commit, commit_rd, commit_tag, commit_val, flush,
    output rd_val, rd_busy, rd_tag, busy_cnt
  );
endinterface

// File: rtl/regfile_rat.sv
// regfile_rat: architectural register file with per-register rename tag and
// busy bit. Tag-qualified commit, misprediction flush, registered busy count.
// Optional macro REGFILE_COMMIT_BYPASS_EN forwards a same-cycle commit value
// (and busy clear on tag match) onto the combinational read ports.
module regfile_rat #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int ROB_W = 4,
  parameter int NRP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  regfile_rat_if.slave     bus
);
  localparam int REG_W = $clog2(NREG);

  logic [XLEN-1:0]  val_q [NREG];
  logic [ROB_W-1:0] tag_q [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [REG_W:0]   busy_cnt_q;
  logic [REG_W:0]   busy_cnt_d;

  logic commit_en;
  logic issue_en;
  logic commit_match;

  logic [NRP*XLEN-1:0]  rd_val_c;
  logic [NRP-1:0]       rd_busy_c;
  logic [NRP*ROB_W-1:0] rd_tag_c;

  // Qualified write enables; x0 is never a target.
  always_comb begin
    commit_en    = bus.rdy && bus.commit && (bus.commit_rd != '0);
    issue_en     = bus.rdy && bus.issue && (bus.issue_rd != '0) && !bus.flush;
    commit_match = busy_q[bus.commit_rd] && (tag_q[bus.commit_rd] == bus.commit_tag);
  end

  // Next-state busy vector and its population count.
  // Issue is applied after the commit clear so it wins on a same-register clash.
  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = '0;
    if (bus.rdy) begin
      if (bus.flush) begin
        busy_d = '0;
      end else begin
        if (commit_en && commit_match) busy_d[bus.commit_rd] = 1'b0;
        if (issue_en)                  busy_d[bus.issue_rd]  = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      busy_cnt_d = busy_cnt_d + (REG_W+1)'(busy_d[i]);
    end
  end

  // Busy bits and busy counter; hold whenever rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else if (bus.rdy) begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Value and tag storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      if (commit_en) val_q[bus.commit_rd] <= bus.commit_val;
      if (issue_en)  tag_q[bus.issue_rd]  <= bus.issue_tag;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_val_c  = '0;
    rd_busy_c = '0;
    rd_tag_c  = '0;
    for (int unsigned k = 0; k < NRP; k++) begin
      logic [REG_W-1:0] a;
      a = bus.rd_addr[k*REG_W +: REG_W];
      rd_val_c[k*XLEN +: XLEN]   = val_q[a];
      rd_busy_c[k]               = busy_q[a];
      rd_tag_c[k*ROB_W +: ROB_W] = tag_q[a];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (bus.commit && (bus.commit_rd != '0) && (a == bus.commit_rd)) begin
        rd_val_c[k*XLEN +: XLEN] = bus.commit_val;
        if (commit_match) begin
          rd_busy_c[k]               = 1'b0;
          rd_tag_c[k*ROB_W +: ROB_W] = '0;
        end
      end
`endif
    end
  end

  assign bus.rd_val   = rd_val_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.rd_tag   = rd_tag_c;
  assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_rat.sv
// tb_regfile_rat: table-driven directed checks of regfile_rat plus short
// hand-written sequences for asynchronous reset and the commit read bypass.
module tb_regfile_rat;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int ROB_W = 4;
  localparam int NRP   = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_rat_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRP(NRP)) bus ();

  regfile_rat #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRP(NRP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic        commit;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [31:0] commit_val;
    logic        flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] v0;
    logic        b0;
    logic [3:0]  t0;
    logic [31:0] v1;
    logic        b1;
    logic [3:0]  t1;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rdy        = 1'b1;
    bus.issue      = 1'b0;
    bus.issue_rd   = '0;
    bus.issue_tag  = '0;
    bus.commit     = 1'b0;
    bus.commit_rd  = '0;
    bus.commit_tag = '0;
    bus.commit_val = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic check_port0(input string name, input logic [31:0] v, input logic b, input logic [3:0] t);
    check({name, ".val0"}, bus.rd_val[31:0], v);
    check({name, ".busy0"}, 32'(bus.rd_busy[0]), 32'(b));
    if (b) check({name, ".tag0"}, 32'(bus.rd_tag[3:0]), 32'(t));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle_inputs();
    bus.rd_addr = '0;

    //          rdy is  ird   itg  cm  crd   ctg  cval          fl  ra0   ra1   v0            b0  t0   v1     b1  t1   cnt
    vecs[0]  = '{1, 0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 32'h0,        0, 5'd5, 5'd0, 32'h0,        0, 4'd0, 32'h0,  0, 4'd0, 6'd0};
    vecs[1]  = '{1, 1, 5'd3, 4'd7, 0, 5'd0, 4'd0, 32'h0,        0, 5'd3, 5'd0, 32'h0,        1, 4'd7, 32'h0,  0, 4'd0, 6'd1};
    vecs[2]  = '{1, 0, 5'd0, 4'd0, 1, 5'd3, 4'd7, 32'hDEADBEEF, 0, 5'd3, 5'd0, 32'hDEADBEEF, 0, 4'd0, 32'h0,  0, 4'd0, 6'd0};
    vecs[3]  = '{1, 1, 5'd4, 4'd2, 0, 5'd0, 4'd0, 32'h0,        0, 5'd4, 5'd3, 32'h0,        1, 4'd2, 32'hDEADBEEF, 0, 4'd0, 6'd1};
    vecs[4]  = '{1, 1, 5'd4, 4'd5, 0, 5'd0, 4'd0, 32'h0,        0, 5'd4, 5'd0, 32'h0,        1, 4'd5, 32'h0,  0, 4'd0, 6'd1};
    vecs[5]  = '{1, 0, 5'd0, 4'd0, 1, 5'd4, 4'd2, 32'h11,       0, 5'd4, 5'd0, 32'h11,       1, 4'd5, 32'h0,  0, 4'd0, 6'd1};
    vecs[6]  = '{1, 0, 5'd0, 4'd0, 1, 5'd4, 4'd5, 32'h22,       0, 5'd4, 5'd0, 32'h22,       0, 4'd0, 32'h0,  0, 4'd0, 6'd0};
    vecs[7]  = '{1, 1, 5'd6, 4'd1, 0, 5'd0, 4'd0, 32'h0,        0, 5'd6, 5'd0, 32'h0,        1, 4'd1, 32'h0,  0, 4'd0, 6'd1};
    vecs[8]  = '{1, 1, 5'd6, 4'd9, 1, 5'd6, 4'd1, 32'h33,       0, 5'd6, 5'd4, 32'h33,       1, 4'd9, 32'h22, 0, 4'd0, 6'd1};
    vecs[9]  = '{1, 1, 5'd1, 4'd3, 0, 5'd0, 4'd0, 32'h0,        0, 5'd1, 5'd6, 32'h0,        1, 4'd3, 32'h33, 1, 4'd9, 6'd2};
    vecs[10] = '{1, 1, 5'd2, 4'd4, 0, 5'd0, 4'd0, 32'h0,        0, 5'd2, 5'd0, 32'h0,        1, 4'd4, 32'h0,  0, 4'd0, 6'd3};
    vecs[11] = '{1, 1, 5'd7, 4'd6, 0, 5'd0, 4'd0, 32'h0,        0, 5'd7, 5'd1, 32'h0,        1, 4'd6, 32'h0,  1, 4'd3, 6'd4};
    vecs[12] = '{1, 1, 5'd8, 4'd10, 0, 5'd0, 4'd0, 32'h0,       1, 5'd8, 5'd7, 32'h0,        0, 4'd0, 32'h0,  0, 4'd0, 6'd0};
    vecs[13] = '{1, 1, 5'd0, 4'd5, 1, 5'd0, 4'd5, 32'h55,       0, 5'd0, 5'd6, 32'h0,        0, 4'd0, 32'h33, 0, 4'd0, 6'd0};
    vecs[14] = '{0, 1, 5'd9, 4'd1, 1, 5'd3, 4'd0, 32'h99,       0, 5'd3, 5'd9, 32'hDEADBEEF, 0, 4'd0, 32'h0,  0, 4'd0, 6'd0};
    vecs[15] = '{1, 1, 5'd9, 4'd2, 0, 5'd0, 4'd0, 32'h0,        0, 5'd9, 5'd0, 32'h0,        1, 4'd2, 32'h0,  0, 4'd0, 6'd1};
    vecs[16] = '{1, 0, 5'd0, 4'd0, 1, 5'd9, 4'd2, 32'h77,       1, 5'd9, 5'd0, 32'h77,       0, 4'd0, 32'h0,  0, 4'd0, 6'd0};
    vecs[17] = '{1, 1, 5'd10, 4'd15, 1, 5'd10, 4'd15, 32'hAA,   0, 5'd10, 5'd9, 32'hAA,      1, 4'd15, 32'h77, 0, 4'd0, 6'd1};

    // Reset state, visible while reset is held.
    bus.rd_addr = {5'd0, 5'd5};
    #1;
    check_port0("reset", 32'h0, 1'b0, 4'd0);
    check("reset.cnt", 32'(bus.busy_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bus.rdy        = vecs[i].rdy;
      bus.issue      = vecs[i].issue;
      bus.issue_rd   = vecs[i].issue_rd;
      bus.issue_tag  = vecs[i].issue_tag;
      bus.commit     = vecs[i].commit;
      bus.commit_rd  = vecs[i].commit_rd;
      bus.commit_tag = vecs[i].commit_tag;
      bus.commit_val = vecs[i].commit_val;
      bus.flush      = vecs[i].flush;
      bus.rd_addr    = {vecs[i].ra1, vecs[i].ra0};
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      check_port0($sformatf("v%0d", i), vecs[i].v0, vecs[i].b0, vecs[i].t0);
      check($sformatf("v%0d.val1", i), bus.rd_val[63:32], vecs[i].v1);
      check($sformatf("v%0d.busy1", i), 32'(bus.rd_busy[1]), 32'(vecs[i].b1));
      if (vecs[i].b1) check($sformatf("v%0d.tag1", i), 32'(bus.rd_tag[7:4]), 32'(vecs[i].t1));
      check($sformatf("v%0d.cnt", i), 32'(bus.busy_cnt), 32'(vecs[i].cnt));
    end

    // Asynchronous reset mid-operation: x10 busy, x3 holds a value.
    @(negedge clk);
    bus.rd_addr = {5'd3, 5'd10};
    #1;
    check_port0("pre_rst", 32'hAA, 1'b1, 4'd15);
    rst = 1'b0;
    #1;
    check_port0("async_rst", 32'h0, 1'b0, 4'd0);
    check("async_rst.val1", bus.rd_val[63:32], 32'h0);
    check("async_rst.cnt", 32'(bus.busy_cnt), 32'd0);
    rst = 1'b1;

    // First edge after reset applies normally: issue x3 tag 7.
    @(negedge clk);
    bus.issue     = 1'b1;
    bus.issue_rd  = 5'd3;
    bus.issue_tag = 4'd7;
    @(posedge clk);
    #1;
    idle_inputs();
    bus.rd_addr = {5'd0, 5'd3};
    #1;
    check_port0("post_rst_issue", 32'h0, 1'b1, 4'd7);
    check("post_rst_issue.cnt", 32'(bus.busy_cnt), 32'd1);

    // Commit x3 tag 7 value 0xAB: same-cycle read depends on the bypass.
    @(negedge clk);
    bus.commit     = 1'b1;
    bus.commit_rd  = 5'd3;
    bus.commit_tag = 4'd7;
    bus.commit_val = 32'hAB;
    #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
    check_port0("bypass", 32'hAB, 1'b0, 4'd0);
    check("bypass.tag0", 32'(bus.rd_tag[3:0]), 32'd0);
`else
    check_port0("no_bypass", 32'h0, 1'b1, 4'd7);
`endif
    check("bypass.cnt", 32'(bus.busy_cnt), 32'd1);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check_port0("after_commit", 32'hAB, 1'b0, 4'd0);
    check("after_commit.cnt", 32'(bus.busy_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_rat.md
# regfile_rat

Parametrised architectural register file with a per-register rename tag (ROB index) and busy bit, for the out-of-order RISC-V core. It sits between the decoder/issue stage, which reads operands and renames destinations, and the ROB commit port, which retires values. It generalises the core register file with:
- configurable width, depth and read-port count;
- tag-qualified commit, so a stale commit cannot clear a newer rename;
- a misprediction flush;
- a registered busy-register counter.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NREG`, 32: architectural register count (power of two); `REG_W = $clog2(NREG)`.
- `ROB_W`, 4: ROB index width.
- `NRP`, 2: read-port count.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rdy`  in  1  global enable; state holds when low.
- `rd_addr`  in  NRP*REG_W  read addresses; port k occupies bits [k*REG_W +: REG_W].
- `rd_val`  out  NRP*XLEN  read values.
- `rd_busy`  out  NRP  1 = operand pending in ROB.
- `rd_tag`  out  NRP*ROB_W  ROB index producing the operand; valid only when busy.
- `issue`  in  1  rename a destination this cycle.
- `issue_rd`  in  REG_W  destination register.
- `issue_tag`  in  ROB_W  ROB index of the issuing instruction.
- `commit`  in  1  ROB retires a register-writing instruction.
- `commit_rd`  in  REG_W  destination register.
- `commit_tag`  in  ROB_W  ROB index being retired.
- `commit_val`  in  XLEN  retired value.
- `flush`  in  1  misprediction recovery; clears all renames.
- `busy_cnt`  out  REG_W+1  number of registers currently busy (registered).

## Operation
State per register: `val`, `busy`, `tag`.
- Register x0 reads 0, not busy, tag 0.
- Writes, issues and commits targeting x0 are ignored; x0 never becomes busy.

Reads (combinational, per port):
- Output the stored `val`/`busy`/`tag`.
- An issue in the same cycle is not visible. The decoder handles rs==rd of the same instruction by reading before renaming.

Commit (when `rdy` is high and `commit_rd != 0`):
- `val[commit_rd] <= commit_val`, always.
- `busy` is cleared only if `busy[commit_rd] && tag[commit_rd] == commit_tag`, and no same-cycle issue targets the same register.
- A commit whose tag does not match (register renamed again later) writes the value but leaves busy/tag untouched.

Issue (when `rdy` is high, `issue_rd != 0`, and `flush` is low):
- `busy[issue_rd] <= 1`, `tag[issue_rd] <= issue_tag`.
- On a same-cycle issue and commit to the same register, the issue wins for busy/tag; the value is still written.

Flush (when `rdy` is high):
- All `busy` bits clear next edge and `tag` values are left as-is.
- A same-cycle commit still writes its value.
- A same-cycle issue is dropped.

`busy_cnt` is updated each edge to the population count of next-state busy bits.

Reset (`rst` low, asynchronous): all `val`, `busy` and `tag` are 0 and `busy_cnt` is 0. Read outputs therefore show 0 / not busy / tag 0 during and after reset.

## Timing
- Read latency is 0 cycles (combinational on `rd_addr` and stored state).
- Issue, commit and flush take effect at the next rising edge. Reads show the new state in the following cycle, except as provided by the bypass under Configuration.
- `busy_cnt` lags state by 0 cycles: it is registered alongside state and always equals the stored busy count.
- With `rdy` low: inputs are ignored and state and `busy_cnt` hold. Reads remain combinational from held state.
- Reset asserted mid-operation discards all renames immediately. The first post-reset edge with `rst` high applies normally.

## Configuration
- `REGFILE_COMMIT_BYPASS_EN` defined:
  - A read port whose address equals `commit_rd` (nonzero) while `commit` is high outputs `commit_val`.
  - If additionally the stored entry is busy with `tag == commit_tag`, the port reports `busy = 0`, `tag = 0`. Otherwise busy/tag are the stored ones.
  - The bypass also applies when `rdy` is low only if `commit` is asserted; the team gates `commit` with `rdy` upstream.
- Undefined: reads return stored state only. A value committing this cycle becomes visible next cycle, and consumers obtain it from the CDB.

## Test plan
- Reset, then read x5 and x0 → `rd_val = 0`, `rd_busy = 0`, `busy_cnt = 0`.
- Issue x3 with tag 7, then commit x3 with tag 7 and value 0xDEADBEEF → after the issue edge x3 is busy with tag 7 and `busy_cnt = 1`; after the commit edge x3 = 0xDEADBEEF, not busy, `busy_cnt = 0`.
- Issue x4 tag 2, issue x4 tag 5, commit x4 tag 2 value 0x11 → x4 val 0x11 still busy with tag 5; commit tag 5 value 0x22 → x4 val 0x22, not busy.
- Same cycle: issue x6 tag 9 and commit x6 tag 1 value 0x33 (x6 previously busy with tag 1) → x6 val 0x33, busy with tag 9.
- Issue x1, x2, x7, then flush together with issue x8 → `busy_cnt = 0` and x8 not busy.
- Issue and commit to x0 → x0 reads 0 and is never busy. With the bypass enabled, reading x3 during commit x3 tag 7 value 0xAB → `rd_val = 0xAB`, `busy = 0` in the same cycle.
